hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipelined CPU. Drives write-enable and flush controls
//  for the PC, IF/ID, ID/EX and EX/MEM registers. Sources: load-use hazards, EX-resolved taken branches,

---
 rtl/hazard_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Drives PC / pipeline-register enables and flushes from load-use, taken-branch,
// fetch-not-ready and MEM-busy conditions. Holds a redirect until fetch accepts it
// and keeps saturating stall / flush statistics.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_INIT    | one cycle after reset: flush IF/ID and ID/EX, PC held
//  ST_RUN     | normal operation, hazards resolved by priority
//  ST_PEND    | taken branch seen while fetch not ready; redirect held in r_redir_q
module hazard_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic [XLEN-1:0]  ex_branch_target,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_write_en,
    output logic             pc_sel,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_flush,
    output logic             ex_mem_write_en,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    logic [XLEN-1:0]   r_redir_q;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_load_use;
    logic              w_branch_accept;
    logic              w_stall_cycle;

    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // A branch is only acted on in RUN when MEM is not freezing the pipe.
    assign w_branch_accept = (r_state == ST_RUN) && !dmem_busy && ex_branch_taken;

    assign w_stall_cycle = ((r_state == ST_RUN) || (r_state == ST_PEND)) && !pc_write_en;

    assign stall_cycles = r_stall_cnt;
    assign flush_events = r_flush_cnt;
    assign state_o      = r_state;

    // Combinational pipeline controls from current state and hazard inputs.
    always_comb begin
        pc_write_en     = 1'b0;
        pc_sel          = 1'b0;
        redirect_pc     = '0;
        if_id_write_en  = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b0;
        if (reset) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if_id_write_en  = 1'b1;
                    if_id_flush     = 1'b1;
                    id_ex_write_en  = 1'b1;
                    id_ex_flush     = 1'b1;
                    ex_mem_write_en = 1'b1;
                end
                ST_RUN: begin
                    if (dmem_busy) begin
                        // full freeze; EX re-presents any branch afterwards
                    end else if (ex_branch_taken) begin
                        pc_write_en     = imem_ready;
                        pc_sel          = 1'b1;
                        redirect_pc     = ex_branch_target;
                        if_id_write_en  = 1'b1;
                        if_id_flush     = 1'b1;
                        id_ex_write_en  = 1'b1;
                        id_ex_flush     = 1'b1;
                        ex_mem_write_en = 1'b1;
                    end else if (w_load_use) begin
                        id_ex_write_en  = 1'b1;
                        id_ex_flush     = 1'b1;
                        ex_mem_write_en = 1'b1;
                    end else if (!imem_ready) begin
                        if_id_write_en  = 1'b1;
                        if_id_flush     = 1'b1;
                        id_ex_write_en  = 1'b1;
                        ex_mem_write_en = 1'b1;
                    end else begin
                        pc_write_en     = 1'b1;
                        if_id_write_en  = 1'b1;
                        id_ex_write_en  = 1'b1;
                        ex_mem_write_en = 1'b1;
                    end
                end
                ST_PEND: begin
                    pc_sel      = 1'b1;
                    redirect_pc = r_redir_q;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (!dmem_busy) begin
                        pc_write_en     = imem_ready;
                        if_id_write_en  = 1'b1;
                        id_ex_write_en  = 1'b1;
                        ex_mem_write_en = 1'b1;
                    end
                end
                default: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
            endcase
        end
    end

    // State sequencing and capture of the pending redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_redir_q <= '0;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_branch_accept && !imem_ready) begin
                        r_redir_q <= ex_branch_target;
                        r_state   <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!dmem_busy && imem_ready) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_cycle && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch_accept && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
